// File: rtl/led_pwm_pkg.sv
// Shared constants and elaboration helpers for the LED PWM fader.
package led_pwm_pkg;

    // Filament drive levels.
    localparam logic LED_ON  = 1'b1;
    localparam logic LED_OFF = 1'b0;

    // Number of clock cycles in one PWM period.
    function automatic int unsigned calc_period(input int unsigned fclk, input int unsigned ms);
        logic [63:0] t;
        t = (64'(fclk) / 64'd1000) * 64'(ms);
        return 32'(t);
    endfunction

    // Counter cycles per brightness unit, so full scale lands at the duty cap.
    function automatic int unsigned calc_ratio(input int unsigned period, input int unsigned pct,
                                               input int unsigned bits);
        logic [63:0] t;
        t = (64'(period) * 64'(pct)) / 64'd100;
        return 32'(t >> bits);
    endfunction

endpackage

// File: rtl/led_pwm_fade_channel.sv
// One PWM channel: fade stepping, duty product, boundary-latched duty and compare.
module led_pwm_fade_channel
    import led_pwm_pkg::*;
#(
    parameter int unsigned B     = 8,
    parameter int unsigned R     = 2,
    parameter int unsigned STEP  = 1,
    parameter int unsigned CNT_W = 10
) (
    input  logic             i_clk,
    input  logic             i_srst,
    input  logic             i_boundary,
    input  logic [CNT_W-1:0] i_count,
    input  logic [B-1:0]     i_target,
    input  logic             i_fade_enable,
    input  logic             i_output_enable,
    output logic             o_led,
    output logic [B-1:0]     o_current,
    output logic             o_busy
);

    localparam int unsigned MAX_V    = (32'd1 << B) - 32'd1;
    localparam int unsigned STEP_SAT = (STEP > MAX_V) ? MAX_V : STEP;
    localparam int unsigned PROD_W   = B + $clog2(R + 1);
    localparam int unsigned CMP_W    = (CNT_W > PROD_W) ? CNT_W : PROD_W;

    localparam logic [B-1:0]      STEP_V  = B'(STEP_SAT);
    localparam logic [PROD_W-1:0] RATIO_V = PROD_W'(R);

    logic [B-1:0]      r_current;
    logic [PROD_W-1:0] r_product;
    logic [PROD_W-1:0] r_duty;
    logic              r_led;
    logic              r_busy;

    logic [B-1:0]      w_next;
    logic [B-1:0]      w_diff;
    logic [CMP_W-1:0]  w_count_ext;
    logic [CMP_W-1:0]  w_duty_ext;
    logic              w_on;

    // Next brightness: jump when fading is off, otherwise a clamped step toward the target.
    always_comb begin
        w_next = r_current;
        w_diff = {B{1'b0}};
        if (!i_fade_enable) begin
            w_next = i_target;
        end else if (i_target > r_current) begin
            w_diff = i_target - r_current;
            w_next = r_current + ((w_diff < STEP_V) ? w_diff : STEP_V);
        end else if (i_target < r_current) begin
            w_diff = r_current - i_target;
            w_next = r_current - ((w_diff < STEP_V) ? w_diff : STEP_V);
        end else begin
            w_next = r_current;
        end
    end

    // Shared-width compare of the period count against the latched duty.
    always_comb begin
        w_count_ext = CMP_W'(i_count);
        w_duty_ext  = CMP_W'(r_duty);
        if (w_count_ext < w_duty_ext) begin
            w_on = 1'b1;
        end else begin
            w_on = 1'b0;
        end
    end

    // Brightness, duty pipeline, busy flag and filament drive registers.
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_current <= {B{1'b0}};
            r_product <= {PROD_W{1'b0}};
            r_duty    <= {PROD_W{1'b0}};
            r_led     <= LED_OFF;
            r_busy    <= 1'b0;
        end else begin
            if (i_boundary) begin
                r_current <= w_next;
                r_duty    <= r_product;
            end
            r_product <= PROD_W'(r_current) * RATIO_V;
            r_busy    <= (r_current != i_target);
            r_led     <= (i_output_enable && w_on) ? LED_ON : LED_OFF;
        end
    end

    assign o_led     = r_led;
    assign o_current = r_current;
    assign o_busy    = r_busy;

endmodule

// File: rtl/led_pwm_fader.sv
// N-channel LED PWM fader: shared down-counting period timer and per-channel faders.
module led_pwm_fader
    import led_pwm_pkg::*;
#(
    parameter int unsigned parm_channel_count           = 16,
    parameter int unsigned parm_value_bits              = 8,
    parameter int unsigned parm_FCLK                    = 40_000_000,
    parameter int unsigned parm_pwm_period_milliseconds = 10,
    parameter int unsigned parm_max_duty_percent        = 50,
    parameter int unsigned parm_fade_step               = 1
) (
    input  logic                                          i_clk,
    input  logic                                          i_srst,
    input  logic [parm_channel_count*parm_value_bits-1:0] i_target_value,
    input  logic [parm_channel_count-1:0]                 i_fade_enable,
    input  logic                                          i_output_enable,
    output logic [parm_channel_count-1:0]                 eo_leds,
    output logic [parm_channel_count*parm_value_bits-1:0] o_current_value,
    output logic [parm_channel_count-1:0]                 o_fade_busy,
    output logic                                          o_period_strobe
);

    localparam int unsigned N     = parm_channel_count;
    localparam int unsigned B     = parm_value_bits;
    localparam int unsigned P     = calc_period(parm_FCLK, parm_pwm_period_milliseconds);
    localparam int unsigned R     = calc_ratio(P, parm_max_duty_percent, B);
    localparam int unsigned CNT_W = (P > 1) ? $clog2(P) : 1;
    localparam int unsigned STEP  = (parm_fade_step < 1) ? 1 : parm_fade_step;

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(P - 1);

    if ((R < 1) || (P < 4) || (B < 2) || (B > 16) ||
        (parm_max_duty_percent < 1) || (parm_max_duty_percent > 100)) begin : g_bad_params
        $fatal(1, "led_pwm_fader: unusable parameters (P=%0d R=%0d B=%0d)", P, R, B);
    end

    logic [CNT_W-1:0] r_count;
    logic             r_strobe;
    logic             w_boundary;

    assign w_boundary = (r_count == {CNT_W{1'b0}});

    // Shared period counter; the reload cycle is the boundary, flagged one cycle later.
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_count  <= RELOAD;
            r_strobe <= 1'b0;
        end else if (w_boundary) begin
            r_count  <= RELOAD;
            r_strobe <= 1'b1;
        end else begin
            r_count  <= r_count - {{(CNT_W-1){1'b0}}, 1'b1};
            r_strobe <= 1'b0;
        end
    end

    assign o_period_strobe = r_strobe;

    for (genvar k = 0; k < N; k++) begin : g_ch
        led_pwm_fade_channel #(
            .B     (B),
            .R     (R),
            .STEP  (STEP),
            .CNT_W (CNT_W)
        ) u_ch (
            .i_clk           (i_clk),
            .i_srst          (i_srst),
            .i_boundary      (w_boundary),
            .i_count         (r_count),
            .i_target        (i_target_value[k*B +: B]),
            .i_fade_enable   (i_fade_enable[k]),
            .i_output_enable (i_output_enable),
            .o_led           (eo_leds[k]),
            .o_current       (o_current_value[k*B +: B]),
            .o_busy          (o_fade_busy[k])
        );
    end

endmodule

// File: tb/tb_led_pwm_fader.sv
// Directed bench for led_pwm_fader: N=4, B=8, P=1024, R=2, fade step 4.
module tb_led_pwm_fader;

    localparam int N = 4;
    localparam int B = 8;

    logic             clk = 1'b0;
    logic             srst;
    logic [N*B-1:0]   tgt;
    logic [N-1:0]     fen;
    logic             oe;
    logic [N-1:0]     eo_leds;
    logic [N*B-1:0]   o_current_value;
    logic [N-1:0]     o_fade_busy;
    logic             o_period_strobe;

    int checks = 0;
    int errors = 0;
    int hi[N];
    int mism[N];
    int exp_duty[N];

    always #5 clk = ~clk;

    led_pwm_fader #(
        .parm_channel_count           (N),
        .parm_value_bits              (B),
        .parm_FCLK                    (1_024_000),
        .parm_pwm_period_milliseconds (1),
        .parm_max_duty_percent        (50),
        .parm_fade_step               (4)
    ) dut (
        .i_clk           (clk),
        .i_srst          (srst),
        .i_target_value  (tgt),
        .i_fade_enable   (fen),
        .i_output_enable (oe),
        .eo_leds         (eo_leds),
        .o_current_value (o_current_value),
        .o_fade_busy     (o_fade_busy),
        .o_period_strobe (o_period_strobe)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance negedge by negedge until the strobe is seen (bounded).
    task automatic wait_boundary(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!o_period_strobe && cyc < 3000);
        if (!o_period_strobe) begin
            checks++;
            errors++;
            $error("FAIL boundary_timeout observed=%0d expected=1024", cyc);
        end
    endtask

    // Sample one full period right after a boundary; LED on while the count before the edge < duty.
    task automatic measure();
        for (int k = 0; k < N; k++) begin
            hi[k] = 0;
            mism[k] = 0;
        end
        for (int j = 1; j <= 1024; j++) begin
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                if (eo_leds[k]) hi[k]++;
                if (eo_leds[k] !== ((1024 - j) < exp_duty[k])) mism[k]++;
            end
        end
    endtask

    initial begin
        int cyc;
        int bad;
        int cur1[4];
        cur1 = '{4, 8, 12, 16};

        // Reset and idle
        srst = 1'b1;
        tgt  = '0;
        fen  = '0;
        oe   = 1'b1;
        repeat (10) @(negedge clk);
        check("reset_leds",    64'(eo_leds),         64'(0));
        check("reset_current", 64'(o_current_value), 64'(0));
        check("reset_busy",    64'(o_fade_busy),     64'(0));
        check("reset_strobe",  64'(o_period_strobe), 64'(0));
        srst = 1'b0;
        cyc = 0;
        bad = 0;
        while (cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (eo_leds !== 4'b0000 || o_current_value !== 32'h0 || o_fade_busy !== 4'b0000) bad++;
            if (o_period_strobe) break;
        end
        check("first_strobe_latency", 64'(cyc), 64'(1024));
        check("idle_outputs", 64'(bad), 64'(0));
        @(negedge clk);
        check("strobe_one_cycle", 64'(o_period_strobe), 64'(0));
        wait_boundary(cyc);

        // Fade disabled jump on ch0
        tgt[7:0] = 8'h80;
        wait_boundary(cyc);
        check("period_length", 64'(cyc), 64'(1024));
        check("ch0_jump", 64'(o_current_value), 64'(32'h0000_0080));
        wait_boundary(cyc);
        exp_duty = '{256, 0, 0, 0};
        measure();
        check("ch0_high_cycles", 64'(hi[0]), 64'(256));
        check("ch0_window", 64'(mism[0]), 64'(0));
        check("ch123_off", 64'(hi[1] + hi[2] + hi[3]), 64'(0));
        check("window_aligned", 64'(o_period_strobe), 64'(1));

        // Fade ch1 from 0 to 0x10 in steps of 4
        tgt[15:8] = 8'h10;
        fen[1]    = 1'b1;
        @(negedge clk);
        check("busy_rise", 64'(o_fade_busy), 64'(4'b0010));
        for (int s = 0; s < 4; s++) begin
            wait_boundary(cyc);
            check("ch1_ramp", 64'(o_current_value), 64'(32'h0000_0080) | 64'(cur1[s] << 8));
            check("ch1_busy_during", 64'(o_fade_busy), 64'(4'b0010));
        end
        @(negedge clk);
        check("ch1_busy_done", 64'(o_fade_busy), 64'(4'b0000));

        // Ramp down, then reverse mid-fade at 8 toward 6
        tgt[15:8] = 8'h00;
        wait_boundary(cyc);
        check("ch1_down_12", 64'(o_current_value), 64'(32'h0000_0C80));
        wait_boundary(cyc);
        check("ch1_down_8", 64'(o_current_value), 64'(32'h0000_0880));
        tgt[15:8] = 8'h06;
        wait_boundary(cyc);
        check("ch1_clamped", 64'(o_current_value), 64'(32'h0000_0680));
        @(negedge clk);
        check("busy_clear_reversal", 64'(o_fade_busy), 64'(4'b0000));
        wait_boundary(cyc);
        exp_duty = '{256, 12, 0, 0};
        measure();
        check("ch1_high_cycles", 64'(hi[1]), 64'(12));
        check("ch01_window", 64'(mism[0] + mism[1] + mism[2] + mism[3]), 64'(0));

        // Full scale on ch2, then output gating
        tgt[23:16] = 8'hFF;
        wait_boundary(cyc);
        check("ch2_jump", 64'(o_current_value), 64'(32'h00FF_0680));
        wait_boundary(cyc);
        exp_duty = '{256, 12, 510, 0};
        measure();
        check("ch2_high_cycles", 64'(hi[2]), 64'(510));
        check("all_window", 64'(mism[0] + mism[1] + mism[2] + mism[3]), 64'(0));
        repeat (600) @(negedge clk);
        check("leds_before_gate", 64'(eo_leds), 64'(4'b0100));
        oe = 1'b0;
        @(negedge clk);
        check("gated_leds", 64'(eo_leds), 64'(4'b0000));
        check("gated_current", 64'(o_current_value), 64'(32'h00FF_0680));
        oe = 1'b1;
        @(negedge clk);
        check("ungated_leds", 64'(eo_leds), 64'(4'b0100));

        // Reset mid-period with ch0 on
        repeat (198) @(negedge clk);
        check("leds_before_reset", 64'(eo_leds), 64'(4'b0101));
        srst = 1'b1;
        @(negedge clk);
        check("midreset_leds",    64'(eo_leds),         64'(0));
        check("midreset_current", 64'(o_current_value), 64'(0));
        check("midreset_busy",    64'(o_fade_busy),     64'(0));
        check("midreset_strobe",  64'(o_period_strobe), 64'(0));
        srst = 1'b0;
        wait_boundary(cyc);
        check("strobe_after_reset", 64'(cyc), 64'(1024));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
